// File: rtl/block_drop_ctrl_pkg.sv
// Shared types and constants for the falling-block controller: FSM encoding,
// playfield geometry, colours and pixel-address helpers.
package block_drop_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAW   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ERASE  = 3'd3,
    ST_UPDATE = 3'd4
  } state_t;

  localparam int unsigned BLK_SIZE = 4;
  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam logic [7:0] START_X = 8'd76;
  localparam logic [7:0] START_Y = 8'd0;
  localparam logic [7:0] X_MAX   = 8'(SCREEN_W - BLK_SIZE);
  localparam logic [7:0] Y_MAX   = 8'(SCREEN_H - BLK_SIZE);

  localparam logic [2:0] BLK_COLOUR = 3'b100;
  localparam logic [2:0] BG_COLOUR  = 3'b000;

  // Pixel counter walks the block row-major: low bits are the column.
  function automatic logic [7:0] pix_x(input logic [7:0] base, input logic [3:0] cnt);
    return base + {6'd0, cnt[1:0]};
  endfunction

  function automatic logic [6:0] pix_y(input logic [7:0] base, input logic [3:0] cnt);
    logic [7:0] sum;
    sum = base + {6'd0, cnt[3:2]};
    return sum[6:0];
  endfunction

endpackage

// File: rtl/block_drop_ctrl_pixel_counter.sv
// 4-bit pixel counter for one 4x4 block pass, with synchronous clear/enable,
// terminal flag at 15 and a look-ahead of the next count.
module block_pixel_counter (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] cnt,
  output logic [3:0] cnt_next,
  output logic       terminal
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 4'd0;
    end else if (enable) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign cnt_next = cnt_d;
  assign terminal = (cnt_q == 4'hF);

endmodule

// File: rtl/block_drop_ctrl.sv
// Drops a 4x4 block one row per step tick via erase/update/redraw pixel plots.
// Define BLOCK_DROP_WRAP_EN to wrap back to the top row instead of landing.
module block_drop_ctrl
  import block_drop_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       go,
  input  logic       step,
  input  logic       move_left,
  input  logic       move_right,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy,
  output logic       landed,
  output state_t     dbg_state
);

  state_t     state_q, state_d;
  logic [7:0] x_pos_q, x_pos_d;
  logic [7:0] y_pos_q, y_pos_d;
  logic       pend_l_q, pend_l_d;
  logic       pend_r_q, pend_r_d;
  logic [7:0] x_out_q, x_out_d;
  logic [6:0] y_out_q, y_out_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       landed_q, landed_d;

  logic       cnt_clear;
  logic       cnt_en;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic       cnt_last;
  logic       at_bottom;
  logic       step_ok;

  block_pixel_counter u_pix_cnt (
    .clock    (clock),
    .resetn   (resetn),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .cnt      (cnt),
    .cnt_next (cnt_next),
    .terminal (cnt_last)
  );

  assign at_bottom = (y_pos_q == Y_MAX);
`ifdef BLOCK_DROP_WRAP_EN
  assign step_ok = step;
`else
  assign step_ok = step && !at_bottom;
`endif

  always_comb begin
    state_d   = state_q;
    x_pos_d   = x_pos_q;
    y_pos_d   = y_pos_q;
    // Move requests stay sticky until UPDATE consumes them.
    pend_l_d  = pend_l_q | move_left;
    pend_r_d  = pend_r_q | move_right;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d   = ST_DRAW;
          cnt_clear = 1'b1;
        end
      end
      ST_DRAW: begin
        if (cnt_last) begin
          state_d   = ST_WAIT;
          cnt_clear = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_WAIT: begin
        if (step_ok) begin
          state_d   = ST_ERASE;
          cnt_clear = 1'b1;
        end
      end
      ST_ERASE: begin
        if (cnt_last) begin
          state_d   = ST_UPDATE;
          cnt_clear = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_UPDATE: begin
        state_d   = ST_DRAW;
        cnt_clear = 1'b1;
        pend_l_d  = 1'b0;
        pend_r_d  = 1'b0;
        if (pend_l_q && !pend_r_q && (x_pos_q != 8'd0)) begin
          x_pos_d = x_pos_q - 8'd1;
        end else if (pend_r_q && !pend_l_q && (x_pos_q != X_MAX)) begin
          x_pos_d = x_pos_q + 8'd1;
        end
        if (y_pos_q < Y_MAX) begin
          y_pos_d = y_pos_q + 8'd1;
        end
`ifdef BLOCK_DROP_WRAP_EN
        else begin
          y_pos_d = START_Y;
        end
`endif
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_clear = 1'b1;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_comb begin
    plot_d   = (state_d == ST_DRAW) || (state_d == ST_ERASE);
    busy_d   = plot_d || (state_d == ST_UPDATE);
    x_out_d  = plot_d ? pix_x(x_pos_d, cnt_next) : 8'd0;
    y_out_d  = plot_d ? pix_y(y_pos_d, cnt_next) : 7'd0;
    colour_d = (state_d == ST_DRAW) ? BLK_COLOUR : BG_COLOUR;
`ifdef BLOCK_DROP_WRAP_EN
    landed_d = 1'b0;
`else
    landed_d = (state_d == ST_WAIT) && (y_pos_d == Y_MAX);
`endif
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      x_pos_q  <= START_X;
      y_pos_q  <= START_Y;
      pend_l_q <= 1'b0;
      pend_r_q <= 1'b0;
      x_out_q  <= 8'd0;
      y_out_q  <= 7'd0;
      colour_q <= 3'd0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_pos_q  <= x_pos_d;
      y_pos_q  <= y_pos_d;
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      x_out_q  <= x_out_d;
      y_out_q  <= y_out_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      landed_q <= landed_d;
    end
  end

  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour_out = colour_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign landed     = landed_q;
  assign dbg_state  = state_q;

  // cnt itself is only observed through cnt_next and the terminal flag.
  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_block_drop_ctrl.sv
// Bench for block_drop_ctrl: randomized moves/steps against a block-level model
// that predicts every plotted pixel through an expected-pixel queue.
module tb_block_drop_ctrl;
  import block_drop_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0;
  logic       step = 1'b0;
  logic       move_left = 1'b0;
  logic       move_right = 1'b0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       busy;
  logic       landed;
  state_t     dbg_state;

  block_drop_ctrl dut (
    .clock      (clock),
    .resetn     (resetn),
    .go         (go),
    .step       (step),
    .move_left  (move_left),
    .move_right (move_right),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot       (plot),
    .busy       (busy),
    .landed     (landed),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [18:0] exp_q[$];

`ifdef BLOCK_DROP_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  // model of the block: top-left corner and pending move requests
  int mx = 76;
  int my = 0;
  bit pl = 1'b0;
  bit pr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_block(input int x, input int y, input logic [2:0] c);
    for (int r = 0; r < 4; r++)
      for (int col = 0; col < 4; col++)
        exp_q.push_back({1'b1, c, 7'(y + r), 8'(x + col)});
  endtask

  // One check per cycle of {plot,colour,y,x}; optionally raises step at index inj.
  task automatic drain(input string tag, input int inj);
    int k;
    logic [18:0] e;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, {13'd0, plot, colour_out, y_out, x_out}, {13'd0, e});
      check({tag, "_busy"}, busy, 1'b1);
      step = (k == inj);
      tick();
      k++;
    end
    step = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    check("rst_out", {13'd0, plot, colour_out, y_out, x_out}, 32'd0);
    check("rst_busy_landed", {busy, landed}, 2'b00);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    resetn = 1'b1;
    tick();
    mx = 76; my = 0; pl = 1'b0; pr = 1'b0;
    exp_q.delete();
  endtask

  task automatic start_draw();
    go = 1'b1;
    tick();
    go = 1'b0;
    push_block(mx, my, 3'b100);
    drain("draw_first", 7);  // step mid-DRAW must be dropped
    for (int i = 0; i < 3; i++) begin
      check("first_wait", {plot, busy, landed}, 3'b000);
      tick();
    end
  endtask

  task automatic pulse_move(input bit l, input bit r);
    move_left = l;
    move_right = r;
    tick();
    move_left = 1'b0;
    move_right = 1'b0;
    pl |= l;
    pr |= r;
  endtask

  task automatic do_step();
    bit bottom;
    bottom = (my == 116);
    step = 1'b1;
    tick();
    step = 1'b0;
    if (bottom && !WRAP) begin
      for (int i = 0; i < 20; i++) begin
        check("bottom_no_plot", {plot, busy}, 2'b00);
        check("bottom_landed", landed, 1'b1);
        tick();
      end
      return;
    end
    push_block(mx, my, 3'b000);
    drain("erase", -1);
    check("update", {plot, busy}, 2'b01);
    if (pl && !pr && mx > 0) mx--;
    else if (pr && !pl && mx < 156) mx++;
    pl = 1'b0; pr = 1'b0;
    my = (my < 116) ? my + 1 : 0;
    tick();
    push_block(mx, my, 3'b100);
    drain("redraw", -1);
    check("wait_idle", {plot, busy}, 2'b00);
    check("landed", landed, (my == 116) && !WRAP);
  endtask

  task automatic rand_move();
    case ($urandom_range(0, 3))
      0: ;
      1: pulse_move(1'b1, 1'b0);
      2: pulse_move(1'b0, 1'b1);
      default: pulse_move(1'b1, 1'b1);
    endcase
    repeat ($urandom_range(0, 3)) tick();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    do_reset();
    check("idle_no_go", {plot, busy}, 2'b00);
    start_draw();

    repeat (25) begin
      rand_move();
      do_step();
    end
    pulse_move(1'b1, 1'b1);
    do_step();
    pulse_move(1'b1, 1'b0);
    do_step();

    // reset while erase pixel 7 is on the bus
    pulse_move(1'b1, 1'b0);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (7) tick();
    check("erase_px7", {13'd0, plot, colour_out, y_out, x_out},
          {13'd0, 1'b1, 3'b000, 7'(my + 1), 8'(mx + 3)});
    resetn = 1'b0;
    tick();
    check("midrst_plot", {plot, busy}, 2'b00);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    resetn = 1'b1;
    tick();
    mx = 76; my = 0; pl = 1'b0; pr = 1'b0;
    start_draw();
    do_step();

    // push against the left wall
    while (mx > 0) begin
      pulse_move(1'b1, 1'b0);
      do_step();
    end
    repeat (2) begin
      pulse_move(1'b1, 1'b0);
      do_step();
    end

    // push against the right wall from a fresh start
    do_reset();
    start_draw();
    while (mx < 156) begin
      pulse_move(1'b0, 1'b1);
      do_step();
    end
    repeat (2) begin
      pulse_move(1'b0, 1'b1);
      do_step();
    end

    // fall to the bottom row, then step past it
    while (my < 116) begin
      if ($urandom_range(0, 1) == 1) rand_move();
      do_step();
    end
    do_step();
    do_step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
